serial_adder_ctrl: RTL and testbench

Sequencer that performs an N-bit addition bit-serially on the lab's 3-to-8-decoder-based 1-bit full adder. The decoder's active-low outputs with sum/carry minterm ORs remain the combinational datapath. Each cycle this block drives the decoder's select and enable inputs, then captures the sum and carry bits it returns. It sits between a board-level operand source (switches or UART) and the external decoder instance, and provides a start/busy/done handshake.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/bit_serializer.sv | 41 ++++
 rtl/serial_adder_ctrl.sv | 102 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder sequencer
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic DEC_E1_ON      = 1'b1;
    localparam logic DEC_E1_OFF     = 1'b0;
    localparam logic DEC_EN_LOW_ON  = 1'b0;
    localparam logic DEC_EN_LOW_OFF = 1'b1;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - operand shift pair and bit counter feeding the decoder select
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_a_bit,
    output logic             o_b_bit,
    output logic             o_last
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_sh_a <= i_op_a;
            r_sh_b <= i_op_b;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_sh_a <= {1'b0, r_sh_a[WIDTH-1:1]};
            r_sh_b <= {1'b0, r_sh_b[WIDTH-1:1]};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_a_bit = r_sh_a[0];
    assign o_b_bit = r_sh_b[0];
    assign o_last  = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - sequences an N-bit add through an external decoder-based full adder
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             dec_fault,
    output logic [2:0]       dec_a,
    output logic             dec_e1,
    output logic             dec_e2_low,
    output logic             dec_e3_low,
    input  logic             dec_si,
    input  logic             dec_ci
);
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_fault;
    logic             w_load;
    logic             w_shift;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_last;

    assign w_load  = (r_state == IDLE) && start;
    assign w_shift = (r_state == RUN);

    bit_serializer #(.WIDTH(WIDTH)) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_op_a  (op_a),
        .i_op_b  (op_b),
        .o_a_bit (w_a_bit),
        .o_b_bit (w_b_bit),
        .o_last  (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_acc   <= '0;
                r_carry <= cin;
            end
            // Sum bits arrive LSB first, so they enter at the MSB and walk down.
            if (w_shift) begin
                r_acc   <= {dec_si, r_acc[WIDTH-1:1]};
                r_carry <= dec_ci;
                if (w_last) begin
                    r_sum  <= {dec_si, r_acc[WIDTH-1:1]};
                    r_cout <= dec_ci;
                end
            end
            if ((r_state == IDLE) && (dec_si || dec_ci)) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign sum        = r_sum;
    assign cout       = r_cout;
    assign dec_fault  = r_fault;
    assign dec_a      = busy ? {w_a_bit, w_b_bit, r_carry} : 3'b000;
    assign dec_e1     = busy ? DEC_E1_ON : DEC_E1_OFF;
    assign dec_e2_low = busy ? DEC_EN_LOW_ON : DEC_EN_LOW_OFF;
    assign dec_e3_low = busy ? DEC_EN_LOW_ON : DEC_EN_LOW_OFF;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl with a behavioural decoder
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             dec_fault;
    logic [2:0]       dec_a;
    logic             dec_e1;
    logic             dec_e2_low;
    logic             dec_e3_low;
    logic             dec_si;
    logic             dec_ci;
    logic             force_si;
    logic             dec_en;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .cout       (cout),
        .dec_fault  (dec_fault),
        .dec_a      (dec_a),
        .dec_e1     (dec_e1),
        .dec_e2_low (dec_e2_low),
        .dec_e3_low (dec_e3_low),
        .dec_si     (dec_si),
        .dec_ci     (dec_ci)
    );

    // Behavioural 3-to-8 decoder full adder; outputs forced low while disabled.
    assign dec_en = dec_e1 && !dec_e2_low && !dec_e3_low;
    assign dec_si = (dec_en && (^dec_a)) || force_si;
    assign dec_ci = dec_en && ((dec_a[2] && dec_a[1]) || (dec_a[2] && dec_a[0]) || (dec_a[1] && dec_a[0]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                           input logic [WIDTH-1:0] es, input logic ec, input bit hold);
        logic [WIDTH-1:0] ma;
        logic [WIDTH-1:0] mb;
        logic             mc;
        int               busy_n;
        bit               got;
        exp_t             e;
        op_a = a; op_b = b; cin = c; start = 1'b1;
        sb.push_back('{es, ec});
        ma = a; mb = b; mc = c;
        busy_n = 0; got = 0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i <= WIDTH + 4 && !got; i++) begin
            if (busy) begin
                check("dec_a", dec_a, {ma[0], mb[0], mc});
                check("en_run", {dec_e1, dec_e2_low, dec_e3_low}, 3'b100);
                mc = (ma[0] & mb[0]) | (ma[0] & mc) | (mb[0] & mc);
                ma = ma >> 1;
                mb = mb >> 1;
                busy_n++;
            end else begin
                check("en_idle", {dec_e1, dec_e2_low, dec_e3_low, dec_a}, 6'b011000);
            end
            if (done) begin
                got = 1;
                check("done_latency", i, WIDTH);
                check("busy_cycles", busy_n, WIDTH);
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sum", sum, e.s);
                    check("cout", cout, e.c);
                end
            end
            @(negedge clk);
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    initial begin
        int seen_done;
        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; force_si = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {busy, done, sum, cout, dec_fault}, '0);
        check("rst_decoder", {dec_a, dec_e1, dec_e2_low, dec_e3_low}, 6'b000011);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_add(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].exp_sum, vecs[v].exp_cout, 1'b0);
        end

        // start held high: first done, one IDLE cycle, then re-accepted
        run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
        check("held_idle_busy", busy, 1'b0);
        run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // reset in the 4th RUN cycle
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_outputs", {busy, done, sum, cout, dec_fault}, '0);
        check("mid_rst_decoder", {dec_a, dec_e1, dec_e2_low, dec_e3_low}, 6'b000011);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen_done++;
            @(negedge clk);
        end
        check("mid_rst_no_done", seen_done, 0);
        run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // datapath fault in IDLE is sticky until reset
        check("fault_clear", dec_fault, 1'b0);
        force_si = 1'b1;
        @(negedge clk);
        force_si = 1'b0;
        check("fault_set", dec_fault, 1'b1);
        run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        check("fault_sticky", dec_fault, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("fault_rst", dec_fault, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
